latch: RTL and testbench

LATCH -- requirements
Module: latch

---
 rtl/latch.sv | 49 ++++
 tb/tb_latch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/latch.sv
// Edge-triggered "latch": a WIDTH-bit register with a capture enable and an
// optional transparent output path that bypasses the register while enabled.
// Storage is strictly flip-flop based; the transparent path is a mux, not a
// level-sensitive latch.
module latch #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter bit                 TRANSPARENT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state: load d_in when enabled, otherwise recirculate the held value.
  always_comb begin
    q_d = q_q;
    if (active) begin
      q_d = d_in;
    end
  end

  // Holding register; reset has priority over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // Output select: reset value while reset is high (covers the undefined
  // register before the first reset edge), live input when transparent and
  // enabled, otherwise the held value.
  always_comb begin
    d_out = q_q;
    if (reset) begin
      d_out = RESET_VALUE;
    end else if (TRANSPARENT && active) begin
      d_out = d_in;
    end
  end

endmodule

// File: tb/tb_latch.sv
// Directed self-checking bench for latch: a 1-bit transparent instance, a
// 1-bit registered instance sharing its stimulus, and an 8-bit transparent
// instance with a non-zero reset value.
module tb_latch;

  logic       clk;
  logic       reset;
  logic       active;
  logic       d;
  logic       out_t;
  logic       out_r;

  logic       wreset;
  logic       wact;
  logic [7:0] wd;
  logic [7:0] wout;

  int checks;
  int failures;

  latch #(.WIDTH(1), .RESET_VALUE(1'b0), .TRANSPARENT(1'b1)) u_t (
    .clk(clk), .reset(reset), .active(active), .d_in(d), .d_out(out_t)
  );

  latch #(.WIDTH(1), .RESET_VALUE(1'b0), .TRANSPARENT(1'b0)) u_r (
    .clk(clk), .reset(reset), .active(active), .d_in(d), .d_out(out_r)
  );

  latch #(.WIDTH(8), .RESET_VALUE(8'hA5), .TRANSPARENT(1'b1)) u_w (
    .clk(clk), .reset(wreset), .active(wact), .d_in(wd), .d_out(wout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    active   = 1'b1;
    d        = 1'b1;
    wreset   = 1'b1;
    wact     = 1'b1;
    wd       = 8'hFF;

    // Reset held for two edges with active=1, d_in=1
    #1;
    chk("rst_pre_t", {7'b0, out_t}, 8'h00);
    chk("rst_pre_r", {7'b0, out_r}, 8'h00);
    chk("rst_pre_w", wout, 8'hA5);
    @(posedge clk); #1;
    chk("rst_e1_t", {7'b0, out_t}, 8'h00);
    chk("rst_e1_r", {7'b0, out_r}, 8'h00);
    @(posedge clk); #1;
    chk("rst_e2_t", {7'b0, out_t}, 8'h00);
    chk("rst_e2_r", {7'b0, out_r}, 8'h00);
    chk("rst_e2_w", wout, 8'hA5);

    // Capture: d_in 0 then 1 before the edge
    @(negedge clk);
    reset = 1'b0; active = 1'b1; d = 1'b0;
    #1;
    chk("cap_d0_t", {7'b0, out_t}, 8'h00);
    chk("cap_d0_r", {7'b0, out_r}, 8'h00);
    d = 1'b1;
    #1;
    chk("cap_d1_t", {7'b0, out_t}, 8'h01);
    chk("cap_d1_r_preedge", {7'b0, out_r}, 8'h00);
    @(posedge clk); #1;
    chk("cap_edge_t", {7'b0, out_t}, 8'h01);
    chk("cap_edge_r", {7'b0, out_r}, 8'h01);
    @(negedge clk);
    active = 1'b0;
    #1;
    chk("cap_hold_t", {7'b0, out_t}, 8'h01);
    chk("cap_hold_r", {7'b0, out_r}, 8'h01);

    // Hold: d_in toggles 0->1->0 over three edges with active=0
    d = 1'b0;
    @(posedge clk); #1;
    chk("hold1_t", {7'b0, out_t}, 8'h01);
    chk("hold1_r", {7'b0, out_r}, 8'h01);
    @(negedge clk); d = 1'b1;
    @(posedge clk); #1;
    chk("hold2_t", {7'b0, out_t}, 8'h01);
    chk("hold2_r", {7'b0, out_r}, 8'h01);
    @(negedge clk); d = 1'b0;
    @(posedge clk); #1;
    chk("hold3_t", {7'b0, out_t}, 8'h01);
    chk("hold3_r", {7'b0, out_r}, 8'h01);

    // Transparency: d_in 0->1->0 between edges with active=1
    @(negedge clk);
    active = 1'b1; d = 1'b0;
    #1;
    chk("tr_0_t", {7'b0, out_t}, 8'h00);
    chk("tr_0_r", {7'b0, out_r}, 8'h01);
    d = 1'b1;
    #1;
    chk("tr_1_t", {7'b0, out_t}, 8'h01);
    d = 1'b0;
    #1;
    chk("tr_2_t", {7'b0, out_t}, 8'h00);
    chk("tr_2_r", {7'b0, out_r}, 8'h01);
    @(posedge clk); #1;
    chk("tr_edge_r", {7'b0, out_r}, 8'h00);
    chk("tr_edge_t", {7'b0, out_t}, 8'h00);

    // Active falls between edges after capturing 1
    @(negedge clk);
    d = 1'b1;
    @(posedge clk); #2;
    d = 1'b0; active = 1'b0;
    #1;
    chk("fall_t", {7'b0, out_t}, 8'h01);
    chk("fall_r", {7'b0, out_r}, 8'h01);
    @(posedge clk); #1;
    chk("fall_next_t", {7'b0, out_t}, 8'h01);
    chk("fall_next_r", {7'b0, out_r}, 8'h01);

    // Reset has priority over capture (held value is 1, d_in=1, active=1)
    @(negedge clk);
    reset = 1'b1; active = 1'b1; d = 1'b1;
    #1;
    chk("prio_comb_t", {7'b0, out_t}, 8'h00);
    chk("prio_comb_r", {7'b0, out_r}, 8'h00);
    @(posedge clk); #1;
    chk("prio_edge_t", {7'b0, out_t}, 8'h00);
    chk("prio_edge_r", {7'b0, out_r}, 8'h00);
    @(negedge clk);
    reset = 1'b0; active = 1'b0;
    #1;
    chk("prio_after_t", {7'b0, out_t}, 8'h00);
    chk("prio_after_r", {7'b0, out_r}, 8'h00);

    // 8-bit instance: capture 3C, then hold against FF
    @(negedge clk);
    wreset = 1'b0; wact = 1'b1; wd = 8'h3C;
    #1;
    chk("w_transp", wout, 8'h3C);
    @(posedge clk); #1;
    chk("w_cap", wout, 8'h3C);
    @(negedge clk);
    wact = 1'b0; wd = 8'hFF;
    #1;
    chk("w_hold_comb", wout, 8'h3C);
    @(posedge clk); #1;
    chk("w_hold_edge", wout, 8'h3C);

    // Per-bit independence: alternating pattern, then hold
    @(negedge clk);
    wact = 1'b1; wd = 8'h5A;
    @(posedge clk); #1;
    chk("w_5a", wout, 8'h5A);
    @(negedge clk);
    wact = 1'b0; wd = 8'h00;
    @(posedge clk); #1;
    chk("w_5a_hold", wout, 8'h5A);

    // Reset back to A5 regardless of active/d_in
    @(negedge clk);
    wreset = 1'b1; wact = 1'b1; wd = 8'h12;
    @(posedge clk); #1;
    chk("w_rst", wout, 8'hA5);
    @(negedge clk);
    wreset = 1'b0; wact = 1'b0;
    #1;
    chk("w_rst_hold", wout, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
